// File: rtl/vend_sequencer.sv
// Vending transaction controller: checks and debits credit, drives the spiral motor,
// confirms the drop and pays change in quarters through the hopper handshake.
module vend_sequencer #(
   parameter int unsigned CREDIT_W      = 12,
   parameter int unsigned MOTOR_CYCLES  = 25000000,
   parameter int unsigned SENSE_TIMEOUT = 100000000,
   parameter int unsigned COIN_TIMEOUT  = 50000000,
   parameter int unsigned COIN_VALUE    = 25
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_item,
   input  logic [CREDIT_W-1:0] req_price,
   input  logic                refund_req,
   input  logic [CREDIT_W-1:0] credit,
   input  logic [3:0]          item_avail,
   output logic                debit_en,
   output logic                credit_add_en,
   output logic [CREDIT_W-1:0] amt,
   output logic                credit_clr,
   output logic [3:0]          stock_dec,
   output logic [3:0]          motor_en,
   input  logic                drop_sense,
   output logic                hopper_pulse,
   input  logic                hopper_ack,
   output logic                vend_done,
   output logic                vend_fail,
   output logic                busy,
   output logic                fault
);

   typedef enum logic [3:0] {
      StIdle,
      StCheck,
      StDebit,
      StMotor,
      StSense,
      StRestore,
      StPayout,
      StCoinWait,
      StCoinDebit,
      StClear,
      StFault
   } state_e;

   // Terminal counts: the counter runs 0..N-1 inside a timed state.
   localparam logic [31:0] MOTOR_LAST = 32'(MOTOR_CYCLES - 1);
   localparam logic [31:0] SENSE_LAST = 32'(SENSE_TIMEOUT - 1);
   localparam logic [31:0] COIN_LAST  = 32'(COIN_TIMEOUT - 1);

   state_e              state;
   logic [31:0]         cnt;
   logic [1:0]          item;
   logic [CREDIT_W-1:0] price;
   logic [3:0]          item_onehot;
   logic [CREDIT_W-1:0] coin_amt;

   assign coin_amt    = CREDIT_W'(COIN_VALUE);
   assign item_onehot = 4'b0001 << item;

   // Refund wins over a simultaneous buy, so ready drops combinationally with refund_req.
   assign req_ready = (state == StIdle) && !fault && !refund_req;
   assign busy      = (state != StIdle);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= StIdle;
         cnt           <= '0;
         item          <= '0;
         price         <= '0;
         debit_en      <= 1'b0;
         credit_add_en <= 1'b0;
         amt           <= '0;
         credit_clr    <= 1'b0;
         stock_dec     <= '0;
         motor_en      <= '0;
         hopper_pulse  <= 1'b0;
         vend_done     <= 1'b0;
         vend_fail     <= 1'b0;
         fault         <= 1'b0;
      end else begin
         debit_en      <= 1'b0;
         credit_add_en <= 1'b0;
         amt           <= '0;
         credit_clr    <= 1'b0;
         stock_dec     <= '0;
         vend_done     <= 1'b0;
         vend_fail     <= 1'b0;

         case (state)
            StIdle: begin
               if (refund_req) begin
                  state <= StPayout;
               end else if (req_valid && req_ready) begin
                  item  <= req_item;
                  price <= req_price;
                  state <= StCheck;
               end
            end

            StCheck: begin
               if ((credit >= price) && item_avail[item]) begin
                  debit_en  <= 1'b1;
                  amt       <= price;
                  stock_dec <= item_onehot;
                  state     <= StDebit;
               end else begin
                  vend_fail <= 1'b1;
                  state     <= StIdle;
               end
            end

            StDebit: begin
               motor_en <= item_onehot;
               cnt      <= '0;
               state    <= StMotor;
            end

            StMotor: begin
               if (cnt == MOTOR_LAST) begin
                  motor_en <= '0;
                  cnt      <= '0;
                  state    <= StSense;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            StSense: begin
               if (drop_sense) begin
                  vend_done <= 1'b1;
                  state     <= StIdle;
               end else if (cnt == SENSE_LAST) begin
                  credit_add_en <= 1'b1;
                  amt           <= price;
                  state         <= StRestore;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            // Credit is given back but the stock decrement stands.
            StRestore: begin
               fault <= 1'b1;
               state <= StFault;
            end

            StPayout: begin
               if (credit >= coin_amt) begin
                  hopper_pulse <= 1'b1;
                  cnt          <= '0;
                  state        <= StCoinWait;
               end else if (credit != '0) begin
                  credit_clr <= 1'b1;
                  state      <= StClear;
               end else begin
                  state <= StIdle;
               end
            end

            StCoinWait: begin
               if (hopper_ack) begin
                  hopper_pulse <= 1'b0;
                  debit_en     <= 1'b1;
                  amt          <= coin_amt;
                  state        <= StCoinDebit;
               end else if (cnt == COIN_LAST) begin
                  hopper_pulse <= 1'b0;
                  fault        <= 1'b1;
                  state        <= StFault;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            // Next PAYOUT compares against the credit already reduced by this debit.
            StCoinDebit: state <= StPayout;

            StClear: state <= StIdle;

            StFault: begin
               motor_en     <= '0;
               hopper_pulse <= 1'b0;
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_vend_sequencer.sv
// Randomized bench for vend_sequencer: environment models for datapath, drop sensor and
// hopper, with outcomes predicted from credit/price/stock arithmetic.
module tb_vend_sequencer;

   localparam int unsigned CW = 12;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_item = '0;
   logic [CW-1:0] req_price = '0;
   logic          refund_req = 1'b0;
   logic [CW-1:0] credit = '0;
   logic [3:0]    item_avail = 4'hF;
   logic          debit_en, credit_add_en, credit_clr;
   logic [CW-1:0] amt;
   logic [3:0]    stock_dec, motor_en;
   logic          drop_sense = 1'b0;
   logic          hopper_pulse;
   logic          hopper_ack = 1'b0;
   logic          vend_done, vend_fail, busy, fault;

   always #5 clk = ~clk;

   vend_sequencer #(
      .CREDIT_W      (CW),
      .MOTOR_CYCLES  (4),
      .SENSE_TIMEOUT (10),
      .COIN_TIMEOUT  (8),
      .COIN_VALUE    (25)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_item      (req_item),
      .req_price     (req_price),
      .refund_req    (refund_req),
      .credit        (credit),
      .item_avail    (item_avail),
      .debit_en      (debit_en),
      .credit_add_en (credit_add_en),
      .amt           (amt),
      .credit_clr    (credit_clr),
      .stock_dec     (stock_dec),
      .motor_en      (motor_en),
      .drop_sense    (drop_sense),
      .hopper_pulse  (hopper_pulse),
      .hopper_ack    (hopper_ack),
      .vend_done     (vend_done),
      .vend_fail     (vend_fail),
      .busy          (busy),
      .fault         (fault)
   );

   int n_tests = 0;
   int n_failed = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Datapath credit register, loadable by the bench.
   logic          dp_load = 1'b0;
   logic [CW-1:0] dp_load_val = '0;
   always @(posedge clk) begin
      if (dp_load)            credit <= dp_load_val;
      else if (credit_clr)    credit <= '0;
      else if (debit_en)      credit <= credit - amt;
      else if (credit_add_en) credit <= credit + amt;
   end

   // Hopper: ack after ack_delay cycles of pulse, released when the pulse drops.
   int ack_delay = 3;
   bit ack_withhold = 1'b0;
   int hop_age = 0;
   always @(negedge clk) begin
      if (hopper_pulse) begin
         hop_age++;
         if (!ack_withhold && hop_age >= ack_delay) hopper_ack = 1'b1;
      end else begin
         hop_age = 0;
         hopper_ack = 1'b0;
      end
   end

   // Drop sensor: rises drop_delay cycles after the motor stops; negative means never.
   int drop_delay = -1;
   int drop_age = 0;
   bit motor_seen = 1'b0;
   always @(negedge clk) begin
      if (motor_en != '0) begin
         motor_seen = 1'b1;
         drop_age = 0;
      end else if (motor_seen && busy) begin
         if (drop_delay >= 0 && drop_age >= drop_delay) drop_sense = 1'b1;
         drop_age++;
      end
      if (!busy) begin
         motor_seen = 1'b0;
         drop_sense = 1'b0;
      end
   end

   // Cumulative event monitor, sampled just after each rising edge.
   int cyc = 0, n_debit = 0, sum_debit = 0, n_add = 0, sum_add = 0, n_clr = 0;
   int n_done = 0, n_fail = 0, n_motor = 0, n_stock = 0, n_hrise = 0, n_hhi = 0, n_bad = 0;
   int last_fail_cyc = 0, last_motor_cyc = 0, last_add_cyc = 0;
   logic [3:0] last_motor = '0, last_stock = '0;
   logic hop_prev = 1'b0;
   always @(posedge clk) begin
      #1;
      cyc++;
      if (debit_en) begin n_debit++; sum_debit += int'(amt); end
      if (credit_add_en) begin n_add++; sum_add += int'(amt); last_add_cyc = cyc; end
      if (!debit_en && !credit_add_en && amt != '0) n_bad++;
      if (credit_clr) n_clr++;
      if (vend_done) n_done++;
      if (vend_fail) begin n_fail++; last_fail_cyc = cyc; end
      if (motor_en != '0) begin
         n_motor++;
         last_motor_cyc = cyc;
         last_motor = motor_en;
         if (!$onehot(motor_en)) n_bad++;
      end
      if (stock_dec != '0) begin n_stock++; last_stock = stock_dec; end
      if (hopper_pulse) n_hhi++;
      if (hopper_pulse && !hop_prev) n_hrise++;
      hop_prev = hopper_pulse;
   end

   int b_debit, b_sdebit, b_add, b_sadd, b_clr, b_done, b_fail, b_motor, b_stock;
   int b_hrise, b_hhi, b_bad;

   task automatic snap();
      b_debit = n_debit; b_sdebit = sum_debit; b_add = n_add; b_sadd = sum_add;
      b_clr = n_clr; b_done = n_done; b_fail = n_fail; b_motor = n_motor;
      b_stock = n_stock; b_hrise = n_hrise; b_hhi = n_hhi; b_bad = n_bad;
   endtask

   task automatic set_env(input int c, input logic [3:0] av);
      @(negedge clk);
      dp_load_val = CW'(c);
      dp_load = 1'b1;
      item_avail = av;
      @(negedge clk);
      dp_load = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy || fault) return;
      end
      check({tag, "/timeout"}, 0, 1);
   endtask

   task automatic send_req(input string tag, input logic [1:0] it, input int pr,
                           output int acc_cyc);
      int k;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({tag, "/ready_before"}, req_ready, 1);
      req_item = it;
      req_price = CW'(pr);
      req_valid = 1'b1;
      @(posedge clk);
      #2;
      acc_cyc = cyc - 1;
      req_valid = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b0;
      refund_req = 1'b0;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "/req_ready"}, req_ready, 1);
      check({tag, "/busy"}, busy, 0);
      check({tag, "/fault"}, fault, 0);
      check({tag, "/motor_en"}, motor_en, 0);
      check({tag, "/hopper"}, hopper_pulse, 0);
      check({tag, "/pulses"},
            {debit_en, credit_add_en, credit_clr, vend_done, vend_fail, stock_dec, amt}, 0);
      @(negedge clk);
      reset = 1'b1;
      ack_withhold = 1'b0;
      ack_delay = 3;
   endtask

   // Buy with the drop arriving; outcome predicted from credit, price and stock.
   task automatic run_buy(input string tag, input int c, input logic [1:0] it, input int p,
                          input logic [3:0] av, input int dd);
      int acc;
      bit ok;
      drop_delay = dd;
      set_env(c, av);
      snap();
      send_req(tag, it, p, acc);
      wait_idle(tag, 60);
      ok = (c >= p) && av[it];
      if (!ok) begin
         check({tag, "/fail"}, n_fail - b_fail, 1);
         check({tag, "/fail_latency"}, last_fail_cyc - acc, 2);
         check({tag, "/no_debit"}, n_debit - b_debit, 0);
         check({tag, "/no_motor"}, n_motor - b_motor, 0);
         check({tag, "/no_done"}, n_done - b_done, 0);
         check({tag, "/credit"}, credit, c);
      end else begin
         check({tag, "/done"}, n_done - b_done, 1);
         check({tag, "/no_fail"}, n_fail - b_fail, 0);
         check({tag, "/debits"}, n_debit - b_debit, 1);
         check({tag, "/debit_amt"}, sum_debit - b_sdebit, p);
         check({tag, "/motor_cycles"}, n_motor - b_motor, 4);
         check({tag, "/motor_item"}, last_motor, 4'b0001 << it);
         check({tag, "/stock_pulses"}, n_stock - b_stock, 1);
         check({tag, "/stock_item"}, last_stock, 4'b0001 << it);
         check({tag, "/credit"}, credit, c - p);
      end
      check({tag, "/stray"}, n_bad - b_bad, 0);
      check({tag, "/ready_after"}, req_ready, 1);
   endtask

   // Refund: whole quarters through the hopper, then any remainder is cleared.
   task automatic run_refund(input string tag, input int c);
      int coins;
      coins = c / 25;
      set_env(c, 4'hF);
      snap();
      @(negedge clk);
      refund_req = 1'b1;
      @(negedge clk);
      refund_req = 1'b0;
      wait_idle(tag, 20 + 12 * coins);
      check({tag, "/coins"}, n_hrise - b_hrise, coins);
      check({tag, "/debits"}, n_debit - b_debit, coins);
      check({tag, "/debit_sum"}, sum_debit - b_sdebit, 25 * coins);
      check({tag, "/clr"}, n_clr - b_clr, (c % 25 != 0) ? 1 : 0);
      check({tag, "/credit"}, credit, 0);
      check({tag, "/no_vend"}, (n_done - b_done) + (n_fail - b_fail), 0);
      check({tag, "/stray"}, n_bad - b_bad, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int c;
      int p;
      repeat (3) @(negedge clk);
      do_reset("reset");

      run_buy("vend_ok", 100, 2'd1, 75, 4'hF, 2);
      run_buy("rej_credit", 50, 2'd1, 75, 4'hF, 2);
      run_buy("rej_stock", 200, 2'd3, 75, 4'b0111, 2);
      run_refund("refund110", 110);
      run_refund("refund0", 0);

      // Refund and buy in the same cycle: refund is taken, the buy is not accepted.
      set_env(60, 4'hF);
      snap();
      @(negedge clk);
      refund_req = 1'b1;
      req_valid = 1'b1;
      req_item = 2'd0;
      req_price = CW'(10);
      #1;
      check("simul/ready_low", req_ready, 0);
      @(negedge clk);
      refund_req = 1'b0;
      req_valid = 1'b0;
      wait_idle("simul", 60);
      check("simul/coins", n_hrise - b_hrise, 2);
      check("simul/clr", n_clr - b_clr, 1);
      check("simul/no_vend", (n_done - b_done) + (n_fail - b_fail) + (n_stock - b_stock), 0);
      check("simul/credit", credit, 0);

      // Hopper never acknowledges.
      ack_withhold = 1'b1;
      set_env(60, 4'hF);
      snap();
      @(negedge clk);
      refund_req = 1'b1;
      @(negedge clk);
      refund_req = 1'b0;
      wait_idle("hop_to", 40);
      check("hop_to/fault", fault, 1);
      check("hop_to/pulse_cycles", n_hhi - b_hhi, 8);
      check("hop_to/pulse_low", hopper_pulse, 0);
      check("hop_to/no_debit", n_debit - b_debit, 0);
      req_valid = 1'b1;
      refund_req = 1'b1;
      repeat (4) @(negedge clk);
      check("hop_to/ready_held", req_ready, 0);
      check("hop_to/busy", busy, 1);
      check("hop_to/pulse_stays_low", hopper_pulse, 0);
      do_reset("hop_to_reset");

      // Item never drops: credit restored, sticky fault.
      drop_delay = -1;
      set_env(200, 4'hF);
      snap();
      send_req("drop_to", 2'd2, 150, acc);
      wait_idle("drop_to", 80);
      check("drop_to/fault", fault, 1);
      check("drop_to/adds", n_add - b_add, 1);
      check("drop_to/add_amt", sum_add - b_sadd, 150);
      check("drop_to/add_latency", last_add_cyc - last_motor_cyc, 11);
      check("drop_to/credit", credit, 200);
      check("drop_to/no_done", n_done - b_done, 0);
      req_valid = 1'b1;
      req_price = CW'(10);
      repeat (5) @(negedge clk);
      check("drop_to/ready_held", req_ready, 0);
      check("drop_to/no_fail", n_fail - b_fail, 0);
      do_reset("drop_to_reset");

      // Reset while the motor runs.
      drop_delay = -1;
      set_env(100, 4'hF);
      send_req("mid_motor", 2'd1, 75, acc);
      for (int i = 0; i < 20 && motor_en == '0; i++) @(negedge clk);
      check("mid_motor/running", motor_en, 4'b0010);
      @(negedge clk);
      do_reset("mid_motor_reset");

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            ack_delay = $urandom_range(1, 4);
            run_refund("rnd_refund", $urandom_range(0, 300));
         end else begin
            c = $urandom_range(0, 400);
            p = $urandom_range(1, 300);
            run_buy("rnd_buy", c, 2'($urandom_range(0, 3)), p, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 5));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
